mem_bist_ctrl: RTL

- Initiator for the 32x8 memory interface: drives read, write, addr and data_in, and samples data_out.
- On a start pulse it writes a deterministic pattern to every address, then reads each location back and compares.
- Reports busy, done, pass, error count and first failing address.
- Sits on the initiator side of the memory port for self-test at bring-up and as a reusable stimulus/checker engine.

---
 rtl/mem_bist_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_bist_ctrl.sv
// March-free write/readback BIST initiator for a 32x8 memory port.
// Optional inverted second pass enabled by defining MEM_BIST_INV_PASS_EN.
module mem_bist_ctrl #(
    parameter int         DEPTH        = 32,
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       read,
    output logic       write,
    output logic [4:0] addr,
    output logic [7:0] data_in,
    input  logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [4:0] fail_addr
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, DONE} state_t;

    localparam logic [4:0] LAST = 5'(DEPTH - 1);
    localparam logic [2:0] LAT  = 3'(READ_LATENCY);

    function automatic logic [7:0] pat(input logic [4:0] a, input logic inv_pass);
        return ({3'b000, a} ^ SEED) ^ {8{inv_pass}};
    endfunction

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       read_nxt, write_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [4:0] addr_nxt, fail_addr_nxt;
    logic [7:0] data_in_nxt, err_count_nxt;
    logic       inv;

`ifdef MEM_BIST_INV_PASS_EN
    logic inv_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inv <= 1'b0;
        else        inv <= inv_nxt;
    end
`else
    assign inv = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            read      <= 1'b0;
            write     <= 1'b0;
            addr      <= 5'd0;
            data_in   <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'd0;
            fail_addr <= 5'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            read      <= read_nxt;
            write     <= write_nxt;
            addr      <= addr_nxt;
            data_in   <= data_in_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_count <= err_count_nxt;
            fail_addr <= fail_addr_nxt;
        end
    end

    // Next values are computed here and registered above, so every output is a flop.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        read_nxt      = 1'b0;
        write_nxt     = 1'b0;
        data_in_nxt   = 8'd0;
        addr_nxt      = addr;
        busy_nxt      = busy;
        done_nxt      = done;
        pass_nxt      = pass;
        err_count_nxt = err_count;
        fail_addr_nxt = fail_addr;
`ifdef MEM_BIST_INV_PASS_EN
        inv_nxt       = inv;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    err_count_nxt = 8'd0;
                    fail_addr_nxt = 5'd0;
                    pass_nxt      = 1'b0;
                    done_nxt      = 1'b0;
                    busy_nxt      = 1'b1;
                    addr_nxt      = 5'd0;
                    write_nxt     = 1'b1;
                    data_in_nxt   = pat(5'd0, 1'b0);
                    state_nxt     = WRITE;
`ifdef MEM_BIST_INV_PASS_EN
                    inv_nxt       = 1'b0;
`endif
                end
            end
            WRITE: begin
                if (addr == LAST) begin
                    addr_nxt  = 5'd0;
                    read_nxt  = 1'b1;
                    state_nxt = READ;
                end else begin
                    addr_nxt    = addr + 5'd1;
                    write_nxt   = 1'b1;
                    data_in_nxt = pat(addr + 5'd1, inv);
                end
            end
            READ: begin
                cnt_nxt   = 3'd1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == LAT) begin
                    if (data_out != pat(addr, inv)) begin
                        if (err_count != 8'hFF) err_count_nxt = err_count + 8'd1;
                        if (err_count == 8'd0)  fail_addr_nxt = addr;
                    end
                    if (addr == LAST) begin
`ifdef MEM_BIST_INV_PASS_EN
                        if (!inv) begin
                            inv_nxt     = 1'b1;
                            addr_nxt    = 5'd0;
                            write_nxt   = 1'b1;
                            data_in_nxt = pat(5'd0, 1'b1);
                            state_nxt   = WRITE;
                        end else begin
                            busy_nxt  = 1'b0;
                            state_nxt = DONE;
                        end
`else
                        busy_nxt  = 1'b0;
                        state_nxt = DONE;
`endif
                    end else begin
                        addr_nxt  = addr + 5'd1;
                        read_nxt  = 1'b1;
                        state_nxt = READ;
                    end
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            DONE: begin
                // err_count already holds the final compare result here.
                done_nxt  = 1'b1;
                pass_nxt  = (err_count == 8'd0);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
